// File: rtl/hs_rr_arbiter_pkg.sv
// Shared types and default sizes for the round-robin 4-phase arbiter.
// The state encoding is shared so debug views agree across modules.
package hs_rr_arbiter_pkg;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_HOLD,
      ARB_REL
   } arb_state_t;

   // Index width for n senders, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hs_rr_arbiter_if.sv
// Sender-side and receiver-side handshake bundle of the arbiter.
// slave is the arbiter view, master is the environment view.
interface hs_rr_arbiter_if
   import hs_rr_arbiter_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W
) ();

   localparam int IDX_W = idx_w(N_REQ);

   logic [N_REQ-1:0]        s_req;
   logic [N_REQ*DATA_W-1:0] s_data;
   logic [N_REQ-1:0]        s_ack;
   logic                    m_req;
   logic [DATA_W-1:0]       m_data;
   logic                    m_ack;
   logic [IDX_W-1:0]        grant_id;
   logic                    busy;

   modport master (
      output s_req,
      output s_data,
      output m_ack,
      input  s_ack,
      input  m_req,
      input  m_data,
      input  grant_id,
      input  busy
   );

   modport slave (
      input  s_req,
      input  s_data,
      input  m_ack,
      output s_ack,
      output m_req,
      output m_data,
      output grant_id,
      output busy
   );

endinterface

// File: rtl/hs_rr_arbiter_picker.sv
// Combinational round-robin pick: rotate by ptr, lowest-bit
// priority encode, then rotate the found offset back.
module rr_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] winner
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

   logic [N_REQ-1:0] rot;
   logic [IDX_W:0]   j;
   logic [IDX_W:0]   off;
   logic [IDX_W:0]   sum;

   // rot[i] is the sender i places after ptr, modulo N_REQ
   always_comb begin
      rot = '0;
      j   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         j = (IDX_W+1)'(i) + {1'b0, ptr};
         if (j >= N_W) begin
            j = j - N_W;
         end
         rot[i] = req[j[IDX_W-1:0]];
      end
   end

   always_comb begin
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = (IDX_W+1)'(i);
         end
      end
   end

   always_comb begin
      sum = off + {1'b0, ptr};
      if (sum >= N_W) begin
         sum = sum - N_W;
      end
      winner = sum[IDX_W-1:0];
      valid  = |req;
   end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack receiver
// among N_REQ senders; grant held for the whole cycle.
module hs_rr_arbiter
   import hs_rr_arbiter_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W
) (
   input logic            clk,
   input logic            rstn,
   hs_rr_arbiter_if.slave bus
);

   localparam int IDX_W = idx_w(N_REQ);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

   arb_state_t        state_q, state_n;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_n;
   logic [IDX_W-1:0]  grant_q, grant_n;
   logic [DATA_W-1:0] data_q, data_n;
   logic [N_REQ-1:0]  s_ack_q, s_ack_n;
   logic              m_req_q, m_req_n;
   logic              busy_q, busy_n;

   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;
   logic [DATA_W-1:0] pick_data;
   logic [N_REQ-1:0]  grant_oh;
   logic              grant_req;

   rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (bus.s_req),
      .ptr    (rr_ptr_q),
      .valid  (pick_valid),
      .winner (pick_idx)
   );

   always_comb begin
      pick_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            pick_data = bus.s_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      grant_oh = '0;
      for (int i = 0; i < N_REQ; i++) begin
         grant_oh[i] = (grant_q == IDX_W'(i));
      end
      grant_req = |(bus.s_req & grant_oh);
   end

   always_comb begin
      state_n  = state_q;
      rr_ptr_n = rr_ptr_q;
      grant_n  = grant_q;
      data_n   = data_q;
      s_ack_n  = s_ack_q;
      m_req_n  = m_req_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               grant_n = pick_idx;
               data_n  = pick_data;
               m_req_n = 1'b1;
               state_n = ARB_REQ;
            end
         end
         ARB_REQ: begin
            if (bus.m_ack) begin
               s_ack_n = grant_oh;
               state_n = ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            if (!grant_req) begin
               m_req_n = 1'b0;
               state_n = ARB_REL;
            end
         end
         ARB_REL: begin
            // last winner becomes lowest priority
            if (!bus.m_ack) begin
               s_ack_n  = '0;
               rr_ptr_n = (grant_q == LAST) ? '0
                        : grant_q + IDX_W'(1);
               state_n  = ARB_IDLE;
            end
         end
         default: begin
            state_n = ARB_IDLE;
         end
      endcase
      busy_n = (state_n != ARB_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         s_ack_q  <= '0;
         m_req_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_n;
         rr_ptr_q <= rr_ptr_n;
         grant_q  <= grant_n;
         data_q   <= data_n;
         s_ack_q  <= s_ack_n;
         m_req_q  <= m_req_n;
         busy_q   <= busy_n;
      end
   end

   assign bus.s_ack    = s_ack_q;
   assign bus.m_req    = m_req_q;
   assign bus.m_data   = data_q;
   assign bus.grant_id = grant_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Bench for hs_rr_arbiter: directed scenarios then random
// transactions against a transaction-level round-robin model.
module tb_hs_rr_arbiter;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;
   int   ptr;

   hs_rr_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

   hs_rr_arbiter #(
      .N_REQ  (4),
      .DATA_W (8)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // first requesting sender at or after p, circularly
   function automatic int model_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   // One full 4-phase transaction; FSM idle with s_req != 0 on entry.
   task automatic run_txn(input int dly, input bit early,
                          input int stuck, input bit chg,
                          input logic [3:0] late);
      int w;
      logic [7:0] d;
      logic [3:0] lm;
      w = model_pick(bus.s_req, ptr);
      d = bus.s_data[w*8 +: 8];
      step();
      chk("grant_mreq", 32'(bus.m_req), 32'd1);
      chk("grant_busy", 32'(bus.busy), 32'd1);
      chk("grant_id", 32'(bus.grant_id), 32'(w));
      chk("grant_data", 32'(bus.m_data), 32'(d));
      chk("grant_sack", 32'(bus.s_ack), 32'd0);
      if (chg) bus.s_data[w*8 +: 8] = d ^ 8'h33;
      if (early) bus.s_req[w] = 1'b0;
      for (int i = 0; i < dly; i++) begin
         step();
         chk("wait_mreq", 32'(bus.m_req), 32'd1);
         chk("wait_sack", 32'(bus.s_ack), 32'd0);
      end
      bus.m_ack = 1'b1;
      step();
      chk("ack_sack", 32'(bus.s_ack), 32'd1 << w);
      chk("ack_data", 32'(bus.m_data), 32'(d));
      bus.s_req[w] = 1'b0;
      lm = late & ~(4'd1 << w);
      bus.s_req = bus.s_req | lm;
      step();
      chk("hold_mreq", 32'(bus.m_req), 32'd0);
      chk("hold_sack", 32'(bus.s_ack), 32'd1 << w);
      for (int i = 0; i < stuck; i++) begin
         step();
         chk("stuck_busy", 32'(bus.busy), 32'd1);
         chk("stuck_sack", 32'(bus.s_ack), 32'd1 << w);
      end
      bus.m_ack = 1'b0;
      step();
      chk("rel_sack", 32'(bus.s_ack), 32'd0);
      chk("rel_busy", 32'(bus.busy), 32'd0);
      chk("rel_gid", 32'(bus.grant_id), 32'(w));
      ptr = (w + 1) % 4;
   endtask

   logic       pm_req;
   logic [7:0] pm_data;
   bit         seen_ack;

   always @(negedge clk) begin
      if (!rstn) begin
         pm_req   = 1'b0;
         seen_ack = 1'b0;
      end else begin
         checks++;
         assert ($onehot0(bus.s_ack)) else begin
            errors++;
            $error("FAIL sack_onehot: observed %b expected onehot0", bus.s_ack);
         end
         checks++;
         assert (bus.s_ack == 4'd0 || bus.busy) else begin
            errors++;
            $error("FAIL sack_busy: observed s_ack %b busy %b", bus.s_ack, bus.busy);
         end
         if (pm_req && bus.m_req) begin
            checks++;
            assert (bus.m_data === pm_data) else begin
               errors++;
               $error("FAIL mdata_stable: observed %h expected %h", bus.m_data, pm_data);
            end
         end
         if (pm_req && !bus.m_req) begin
            checks++;
            assert (seen_ack) else begin
               errors++;
               $error("FAIL mreq_early_fall: observed fall expected after m_ack");
            end
            seen_ack = 1'b0;
         end
         if (bus.m_req && bus.m_ack) seen_ack = 1'b1;
         pm_req  = bus.m_req;
         pm_data = bus.m_data;
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      ptr       = 0;
      rstn      = 1'b0;
      bus.s_req  = 4'd0;
      bus.s_data = 32'd0;
      bus.m_ack  = 1'b0;
      step();
      step();
      chk("rst_mreq", 32'(bus.m_req), 32'd0);
      chk("rst_sack", 32'(bus.s_ack), 32'd0);
      chk("rst_data", 32'(bus.m_data), 32'd0);
      chk("rst_gid", 32'(bus.grant_id), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rstn = 1'b1;
      step();

      // m_ack while idle is ignored
      bus.m_ack = 1'b1;
      step();
      step();
      chk("idle_ack_busy", 32'(bus.busy), 32'd0);
      chk("idle_ack_mreq", 32'(bus.m_req), 32'd0);
      chk("idle_ack_sack", 32'(bus.s_ack), 32'd0);
      bus.m_ack = 1'b0;
      step();

      // all four at once: order 0,1,2,3
      bus.s_req  = 4'b1111;
      bus.s_data = 32'h44332211;
      for (int i = 0; i < 4; i++) begin
         chk("all_order", 32'(model_pick(bus.s_req, ptr)), 32'(i));
         run_txn(1, 1'b0, 0, 1'b0, 4'd0);
      end

      // single sender 2, ack 2 cycles after m_req
      bus.s_req  = 4'b0100;
      bus.s_data[16 +: 8] = 8'hA5;
      run_txn(2, 1'b0, 0, 1'b0, 4'd0);
      chk("single_ptr", 32'(ptr), 32'd3);

      // wrap: sender 3 then sender 0
      bus.s_req = 4'b1001;
      run_txn(0, 1'b0, 1, 1'b0, 4'd0);
      chk("wrap_ptr", 32'(ptr), 32'd0);
      run_txn(1, 1'b1, 0, 1'b0, 4'd0);

      // data stability: 11 -> 22 after grant
      bus.s_req = 4'b0001;
      bus.s_data[0 +: 8] = 8'h11;
      run_txn(2, 1'b0, 0, 1'b1, 4'd0);
      chk("stab_sdata", 32'(bus.s_data[0 +: 8]), 32'h22);

      // late arrival of sender 1 during sender 0 hold
      bus.s_req = 4'b0001;
      run_txn(1, 1'b0, 2, 1'b0, 4'b0010);
      run_txn(0, 1'b0, 0, 1'b0, 4'd0);

      // reset in ARB_HOLD; scan restarts at 0
      bus.s_req = 4'b1010;
      chk("rst_pick", 32'(model_pick(bus.s_req, ptr)), 32'd3);
      step();
      chk("pre_rst_gid", 32'(bus.grant_id), 32'd3);
      bus.m_ack = 1'b1;
      step();
      chk("pre_rst_sack", 32'(bus.s_ack), 32'b1000);
      #1;
      rstn = 1'b0;
      #1;
      chk("arst_mreq", 32'(bus.m_req), 32'd0);
      chk("arst_sack", 32'(bus.s_ack), 32'd0);
      chk("arst_data", 32'(bus.m_data), 32'd0);
      chk("arst_gid", 32'(bus.grant_id), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      bus.m_ack = 1'b0;
      step();
      rstn = 1'b1;
      ptr = 0;
      run_txn(0, 1'b0, 0, 1'b0, 4'd0);
      run_txn(1, 1'b0, 0, 1'b0, 4'd0);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!bus.s_req[i] && $urandom_range(0, 1) == 1) begin
               bus.s_req[i] = 1'b1;
               bus.s_data[i*8 +: 8] = 8'($urandom);
            end
         end
         if (bus.s_req == 4'd0) begin
            bus.s_req[$urandom_range(0, 3)] = 1'b1;
         end
         run_txn(int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)),
                 4'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
